// File: rtl/br_puf_pkg.sv
// Shared types, defaults and helpers for the bistable-ring PUF evaluation sequencer.
package br_puf_pkg;

    localparam int unsigned BR_CW            = 128;
    localparam int unsigned BR_RST_CYCLES    = 4;
    localparam int unsigned BR_SETTLE_CYCLES = 64;

    typedef logic [2:0] br_state_t;

    localparam br_state_t ST_IDLE     = 3'd0;
    localparam br_state_t ST_RING_RST = 3'd1;
    localparam br_state_t ST_SETTLE   = 3'd2;
    localparam br_state_t ST_SAMPLE   = 3'd3;
    localparam br_state_t ST_VOTE     = 3'd4;
    localparam br_state_t ST_DONE     = 3'd5;

    // Strict majority of n votes.
    function automatic logic majority(input int unsigned ones, input int unsigned n);
        return ones > (n / 2);
    endfunction

endpackage

// File: rtl/br_puf_eval_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous ring output.
module br_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/br_puf_eval_ctrl.sv
// Sequences repeated bistable-ring evaluations per challenge rotation and
// majority-votes the synchronized ring output into a response word.
module br_puf_eval_ctrl
    import br_puf_pkg::*;
#(
    parameter int unsigned CW            = BR_CW,
    parameter int unsigned RESP_BITS     = 8,
    parameter int unsigned NUM_EVAL      = 7,
    parameter int unsigned RST_CYCLES    = BR_RST_CYCLES,
    parameter int unsigned SETTLE_CYCLES = BR_SETTLE_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CW-1:0]        req_challenge,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic [RESP_BITS-1:0] resp_unstable,
    output logic                 br_reset,
    output logic [CW-1:0]        br_c,
    input  logic                 br_out
);

    localparam int unsigned EW        = $clog2(NUM_EVAL + 1);
    localparam int unsigned PHASE_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
    localparam int unsigned BW        = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [PW-1:0] RST_LAST    = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] EVAL_LAST   = EW'(NUM_EVAL - 1);
    localparam logic [EW-1:0] EVAL_ALL    = EW'(NUM_EVAL);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

    br_state_t       state, state_nxt;
    logic [PW-1:0]   phase;
    logic [EW-1:0]   eval_cnt;
    logic [EW-1:0]   ones_cnt;
    logic [BW-1:0]   bit_idx;
    logic            br_out_s;

    br_sync2 u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (br_out),
        .q     (br_out_s)
    );

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (req_valid) state_nxt = ST_RING_RST;
            ST_RING_RST: if (phase == RST_LAST) state_nxt = ST_SETTLE;
            ST_SETTLE:   if (phase == SETTLE_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE:   state_nxt = (eval_cnt == EVAL_LAST) ? ST_VOTE : ST_RING_RST;
            ST_VOTE:     state_nxt = (bit_idx == BIT_LAST) ? ST_DONE : ST_RING_RST;
            ST_DONE:     if (resp_valid && resp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Datapath; the ring is held in reset whenever the sequencer is in reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            br_reset      <= 1'b1;
            br_c          <= '0;
            phase         <= '0;
            eval_cnt      <= '0;
            ones_cnt      <= '0;
            bit_idx       <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_unstable <= '0;
        end else begin
            br_reset <= (state_nxt == ST_RING_RST);
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        br_c     <= req_challenge;
                        bit_idx  <= '0;
                        eval_cnt <= '0;
                        ones_cnt <= '0;
                        phase    <= '0;
                    end
                end
                ST_RING_RST: phase <= (phase == RST_LAST) ? '0 : phase + PW'(1);
                ST_SETTLE:   phase <= (phase == SETTLE_LAST) ? '0 : phase + PW'(1);
                ST_SAMPLE: begin
                    ones_cnt <= ones_cnt + EW'(br_out_s);
                    eval_cnt <= eval_cnt + EW'(1);
                end
                ST_VOTE: begin
                    resp_data[bit_idx]     <= majority(32'(ones_cnt), NUM_EVAL);
                    resp_unstable[bit_idx] <= (ones_cnt != '0) && (ones_cnt != EVAL_ALL);
                    br_c                   <= {br_c[0], br_c[CW-1:1]};
                    eval_cnt               <= '0;
                    ones_cnt               <= '0;
                    if (bit_idx != BIT_LAST) bit_idx <= bit_idx + BW'(1);
                end
                // resp_valid rises the cycle after DONE is entered and drops on handshake.
                ST_DONE: resp_valid <= !(resp_valid && resp_ready);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_br_puf_eval_ctrl.sv
// Self-checking bench for br_puf_eval_ctrl with a ring-macro stub and a vote-level reference model.
module tb_br_puf_eval_ctrl;

    localparam int unsigned CW = 128;
    localparam int unsigned RB = 8;
    localparam int unsigned NE = 7;
    localparam int unsigned LAT = RB * (NE * (4 + 64 + 1) + 1) + 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_challenge = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [RB-1:0] resp_data;
    logic [RB-1:0] resp_unstable;
    logic          br_reset;
    logic [CW-1:0] br_c;
    logic          br_out = 1'b0;

    br_puf_eval_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_unstable (resp_unstable),
        .br_reset      (br_reset),
        .br_c          (br_c),
        .br_out        (br_out)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc = cyc + 1;

    // Stub configuration written by the main sequence, read by the stub.
    int mode = 0;
    int base_pulse = 0;

    // Stub/monitor state.
    int       pulse_cnt = 0;
    int       width_err = 0;
    int       c_err = 0;
    int       hi_len = 0;
    bit       in_pulse = 0;
    logic     prev_rst = 1'b1;
    logic [CW-1:0] prev_c = '0;
    int       style = 0;
    logic     samples [0:63];

    // Ring stub: a new output level per evaluation, held for the whole evaluation.
    always @(posedge CLK) begin
        int  rel;
        logic v;
        #1;
        if (RESET) begin
            in_pulse = 0;
            hi_len = 0;
        end else begin
            if (br_reset && !prev_rst) begin
                rel = pulse_cnt - base_pulse;
                case (mode)
                    0: v = 1'b1;
                    1: v = br_c[0];
                    2: v = ((rel / 7 == 0) && (rel % 7 < 4)) || ((rel / 7 == 1) && (rel % 7 < 3));
                    default: begin
                        if (rel % 7 == 0) style = int'($urandom_range(0, 2));
                        v = (style == 2) ? 1'($urandom_range(0, 1)) : 1'(style);
                    end
                endcase
                if (rel >= 0 && rel < 64) samples[rel] = v;
                br_out = v;
                pulse_cnt = pulse_cnt + 1;
                in_pulse = 1;
                hi_len = 1;
            end else if (br_reset && in_pulse) begin
                hi_len = hi_len + 1;
            end
            if (!br_reset && prev_rst && in_pulse) begin
                if (hi_len != 4) width_err = width_err + 1;
                in_pulse = 0;
            end
            if (br_reset && prev_rst && br_c !== prev_c) c_err = c_err + 1;
        end
        prev_rst = br_reset;
        prev_c = br_c;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bit k is the strict majority of evaluations 7k..7k+6; unstable if mixed.
    task automatic model(output logic [RB-1:0] d, output logic [RB-1:0] u);
        for (int k = 0; k < RB; k++) begin
            int ones = 0;
            for (int j = 0; j < NE; j++) ones += int'(samples[k * NE + j]);
            d[k] = (ones * 2 > NE);
            u[k] = (ones != 0) && (ones != NE);
        end
    endtask

    int acc_cyc, w0, c0;

    // Called on a negedge while IDLE; returns on the negedge after the accept edge.
    task automatic start_req(input logic [CW-1:0] chal, input int m);
        mode = m;
        base_pulse = pulse_cnt;
        w0 = width_err;
        c0 = c_err;
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        req_challenge = chal;
        req_valid = 1'b1;
        @(negedge CLK);
        acc_cyc = cyc;
        req_valid = 1'b0;
        chk("br_c_loaded", br_c[63:0], chal[63:0]);
    endtask

    task automatic finish_req(input string tag, input bit dir, input logic [RB-1:0] ed,
                              input logic [RB-1:0] eu);
        logic [RB-1:0] md, mu;
        for (int i = 0; i < 5000 && !resp_valid; i++) @(negedge CLK);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(LAT));
        model(md, mu);
        chk({tag, "_data_model"}, 64'(resp_data), 64'(md));
        chk({tag, "_unstable_model"}, 64'(resp_unstable), 64'(mu));
        if (dir) begin
            chk({tag, "_data"}, 64'(resp_data), 64'(ed));
            chk({tag, "_unstable"}, 64'(resp_unstable), 64'(eu));
        end
        chk({tag, "_pulses"}, 64'(pulse_cnt - base_pulse), 64'(RB * NE));
        chk({tag, "_pulse_width"}, 64'(width_err - w0), 64'd0);
        chk({tag, "_br_c_in_reset"}, 64'(c_err - c0), 64'd0);
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [CW-1:0] ch;
        logic [RB-1:0] hd, hu;
        int got;

        // Reset values.
        repeat (3) @(negedge CLK);
        chk("rst_br_reset", 64'(br_reset), 64'd1);
        chk("rst_br_c", br_c[63:0], 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_unstable", 64'(resp_unstable), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_release_br_reset", 64'(br_reset), 64'd0);

        // Constant-one ring.
        ch = {$urandom, $urandom, $urandom, $urandom};
        start_req(ch, 0);
        finish_req("ones", 1, 8'hFF, 8'h00);
        handshake("ones");

        // Ring follows br_c[0]; back-to-back accept.
        ch = {$urandom, $urandom, $urandom, 24'($urandom), 8'hA5};
        start_req(ch, 1);
        finish_req("follow", 1, 8'hA5, 8'h00);

        // Hold the response with req_valid asserted.
        hd = resp_data;
        hu = resp_unstable;
        req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (resp_data !== hd || resp_unstable !== hu || req_ready !== 1'b0 || resp_valid !== 1'b1)
                got++;
        end
        chk("hold_stable", 64'(got), 64'd0);
        chk("hold_no_pulse", 64'(pulse_cnt - base_pulse), 64'(RB * NE));
        req_valid = 1'b0;
        handshake("hold");

        // Split votes on bits 0 and 1.
        ch = {$urandom, $urandom, $urandom, $urandom};
        start_req(ch, 2);
        finish_req("split", 1, 8'h01, 8'h03);
        handshake("split");

        // Randomized ring behaviour against the reference model.
        for (int r = 0; r < 2; r++) begin
            ch = {$urandom, $urandom, $urandom, $urandom};
            start_req(ch, 3);
            finish_req("rand", 0, '0, '0);
            handshake("rand");
        end

        // Abort during SETTLE of bit 3.
        ch = {$urandom, $urandom, $urandom, $urandom};
        start_req(ch, 3);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((pulse_cnt - base_pulse) == 22 && !br_reset) begin
                got = 1;
                break;
            end
            @(negedge CLK);
        end
        chk("abort_reached_bit3", 64'(got), 64'd1);
        RESET = 1'b1;
        #1;
        chk("abort_br_reset", 64'(br_reset), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_release_br_reset", 64'(br_reset), 64'd0);
        chk("abort_no_resp", 64'(resp_valid), 64'd0);

        ch = {$urandom, $urandom, $urandom, $urandom};
        start_req(ch, 3);
        finish_req("after_abort", 0, '0, '0);
        handshake("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
